// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side hazard signals grouped for the hazard controller.
// The master modport is the pipeline datapath; the slave modport is the controller.
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if;
    logic [4:0]  ID_registers_Rs;
    logic [4:0]  ID_registers_Rt;
    logic        ID_uses_Rt;
    logic        ID_branch_taken;
    logic [4:0]  EX_register_Rt;
    logic        EX_MemRead;
    logic        MEM_mem_req;
    logic        MEM_mem_ready;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        pipe_hold;
    logic        mem_timeout;
    logic [15:0] stall_count;

    // mem_req stays high until mem_ready is seen or the datapath aborts by dropping mem_req;
    // a transfer completes in the cycle where mem_req and mem_ready are both high.
    modport master (
        output ID_registers_Rs, ID_registers_Rt, ID_uses_Rt, ID_branch_taken,
        output EX_register_Rt, EX_MemRead, MEM_mem_req, MEM_mem_ready,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
        input  mem_timeout, stall_count
    );

    modport slave (
        input  ID_registers_Rs, ID_registers_Rt, ID_uses_Rt, ID_branch_taken,
        input  EX_register_Rt, EX_MemRead, MEM_mem_req, MEM_mem_ready,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold,
        output mem_timeout, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use bubbles, taken-branch flushes and bounded memory-wait holds.
// Optional stall-cycle counter built only when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.slave    hz,
    output logic                 dbg_state_o,
    output logic [7:0]           dbg_wait_cnt_o
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       load_use, at_limit, hold;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;

    assign load_use = hz.EX_MemRead && (hz.EX_register_Rt != 5'd0) &&
                      ((hz.EX_register_Rt == hz.ID_registers_Rs) ||
                       (hz.ID_uses_Rt && (hz.EX_register_Rt == hz.ID_registers_Rt)));
    assign at_limit = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LIMIT);
    // The hold drops in the timeout cycle so the pipeline can move past the stuck access.
    assign hold     = hz.MEM_mem_req && !hz.MEM_mem_ready && !at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (hold) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!hz.MEM_mem_req || hz.MEM_mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (at_limit) begin
                    state_d       = RUN;
                    wait_cnt_d    = 8'd0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Branch loses to load_use so the held ID branch is re-evaluated next cycle.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hold) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (hz.ID_branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    assign hz.PC_write     = pc_write;
    assign hz.IF_ID_write  = if_id_write;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_flush  = id_ex_flush;
    assign hz.pipe_hold    = pipe_hold;
    assign hz.mem_timeout  = mem_timeout_q;
    assign dbg_state_o     = state_q;
    assign dbg_wait_cnt_o  = wait_cnt_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_count = stall_cnt_q;
`else
    assign hz.stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
// Stall-count expectations follow HAZARD_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
    logic       clk;
    logic       rst_n;
    logic       dbg_state;
    logic [7:0] dbg_wait_cnt;
    int         n_cmp;
    int         n_fail;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold}
    localparam logic [4:0] C_NORMAL = 5'b11000;
    localparam logic [4:0] C_LOADUSE = 5'b00010;
    localparam logic [4:0] C_BRANCH = 5'b11100;
    localparam logic [4:0] C_HOLD = 5'b00001;
    localparam logic [4:0] C_RESET = 5'b00110;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.WAIT_LIMIT(8'd4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hz             (hz.slave),
        .dbg_state_o    (dbg_state),
        .dbg_wait_cnt_o (dbg_wait_cnt)
    );

    logic [4:0] ctl;
    assign ctl = {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_flush, hz.pipe_hold};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // drivers
    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic br, input logic [4:0] ex_rt, input logic memrd,
                          input logic req, input logic rdy);
        hz.ID_registers_Rs = rs;
        hz.ID_registers_Rt = rt;
        hz.ID_uses_Rt      = uses;
        hz.ID_branch_taken = br;
        hz.EX_register_Rt  = ex_rt;
        hz.EX_MemRead      = memrd;
        hz.MEM_mem_req     = req;
        hz.MEM_mem_ready   = rdy;
    endtask

    task automatic set_idle();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
        n_cmp++; if (hz.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", hz.mem_timeout); end
        n_cmp++; if (hz.stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", hz.stall_count); end
        n_cmp++; if ({dbg_state, dbg_wait_cnt} !== 9'd0) begin n_fail++; $display("FAIL reset_state: got %b/%0d want 0/0", dbg_state, dbg_wait_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); set_in(5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_LOADUSE) begin n_fail++; $display("FAIL lu_rs: got %b want %b", ctl, C_LOADUSE); end
        @(negedge clk); set_in(5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_release: got %b want %b", ctl, C_NORMAL); end
        n_cmp++; if (hz.stall_count !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL lu_stall1: got %0d want %0d", hz.stall_count, PERF ? 1 : 0); end
        @(negedge clk); set_in(5'd4, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_LOADUSE) begin n_fail++; $display("FAIL lu_rt: got %b want %b", ctl, C_LOADUSE); end
        @(negedge clk); set_idle(); #1;
        n_cmp++; if (hz.stall_count !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL lu_stall2: got %0d want %0d", hz.stall_count, PERF ? 2 : 0); end
    endtask

    task automatic test_rt_filter();
        @(negedge clk); set_in(5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL filt_r0: got %b want %b", ctl, C_NORMAL); end
        @(negedge clk); set_in(5'd3, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL filt_uses_rt: got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_branch();
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL branch: got %b want %b", ctl, C_BRANCH); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk); set_in(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_LOADUSE) begin n_fail++; $display("FAIL simul_lu: got %b want %b", ctl, C_LOADUSE); end
        @(negedge clk); set_in(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); #1;
        n_cmp++; if (ctl !== C_BRANCH) begin n_fail++; $display("FAIL simul_branch: got %b want %b", ctl, C_BRANCH); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0); #1;
        n_cmp++; if ({ctl, dbg_state} !== {C_HOLD, 1'b0}) begin n_fail++; $display("FAIL mw_c1: got %b/%b want %b/0", ctl, dbg_state, C_HOLD); end
        // hold must win over a coincident load-use
        @(negedge clk); set_in(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); #1;
        n_cmp++; if ({ctl, dbg_state, dbg_wait_cnt} !== {C_HOLD, 1'b1, 8'd1}) begin n_fail++; $display("FAIL mw_c2: got %b/%b/%0d want %b/1/1", ctl, dbg_state, dbg_wait_cnt, C_HOLD); end
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0); #1;
        n_cmp++; if ({ctl, dbg_wait_cnt} !== {C_HOLD, 8'd2}) begin n_fail++; $display("FAIL mw_c3: got %b/%0d want %b/2", ctl, dbg_wait_cnt, C_HOLD); end
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1); #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL mw_ready: got %b want %b", ctl, C_NORMAL); end
        @(negedge clk); set_idle(); #1;
        n_cmp++; if ({dbg_state, dbg_wait_cnt} !== 9'd0) begin n_fail++; $display("FAIL mw_back_run: got %b/%0d want 0/0", dbg_state, dbg_wait_cnt); end
        n_cmp++; if (hz.stall_count !== (PERF ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL mw_stall: got %0d want %0d", hz.stall_count, PERF ? 3 : 0); end
        n_cmp++; if (hz.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL mw_no_timeout: got %b want 0", hz.mem_timeout); end
    endtask

    task automatic test_abort();
        do_reset();
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk); set_idle(); #1;
        n_cmp++; if ({ctl, dbg_state} !== {C_NORMAL, 1'b1}) begin n_fail++; $display("FAIL abort_cycle: got %b/%b want %b/1", ctl, dbg_state, C_NORMAL); end
        @(negedge clk); #1;
        n_cmp++; if ({dbg_state, dbg_wait_cnt, hz.mem_timeout} !== 10'd0) begin n_fail++; $display("FAIL abort_after: got %b/%0d/%b want 0/0/0", dbg_state, dbg_wait_cnt, hz.mem_timeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0); #1;
            n_cmp++; if (ctl !== C_HOLD) begin n_fail++; $display("FAIL to_hold_c%0d: got %b want %b", i, ctl, C_HOLD); end
        end
        @(negedge clk); #1;
        n_cmp++; if ({ctl, dbg_wait_cnt, hz.mem_timeout} !== {C_NORMAL, 8'd4, 1'b0}) begin n_fail++; $display("FAIL to_limit: got %b/%0d/%b want %b/4/0", ctl, dbg_wait_cnt, hz.mem_timeout, C_NORMAL); end
        @(negedge clk); set_idle(); #1;
        n_cmp++; if ({hz.mem_timeout, dbg_state} !== 2'b10) begin n_fail++; $display("FAIL to_flag: got %b/%b want 1/0", hz.mem_timeout, dbg_state); end
        n_cmp++; if (hz.stall_count !== (PERF ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL to_stall: got %0d want %0d", hz.stall_count, PERF ? 4 : 0); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (hz.mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", hz.mem_timeout); end
    endtask

    task automatic test_mid_wait_reset();
        do_reset();
        @(negedge clk); set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({dbg_state, dbg_wait_cnt} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL mwr_pre: got %b/%0d want 1/2", dbg_state, dbg_wait_cnt); end
        n_cmp++; if (hz.stall_count !== (PERF ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL mwr_pre_stall: got %0d want %0d", hz.stall_count, PERF ? 2 : 0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({ctl, dbg_state, dbg_wait_cnt} !== {C_RESET, 1'b0, 8'd0}) begin n_fail++; $display("FAIL mwr_async: got %b/%b/%0d want %b/0/0", ctl, dbg_state, dbg_wait_cnt, C_RESET); end
        n_cmp++; if ({hz.stall_count, hz.mem_timeout} !== 17'd0) begin n_fail++; $display("FAIL mwr_regs: got %0d/%b want 0/0", hz.stall_count, hz.mem_timeout); end
        repeat (6) @(negedge clk);
        #1;
        n_cmp++; if ({hz.stall_count, hz.mem_timeout, dbg_state} !== 18'd0) begin n_fail++; $display("FAIL mwr_held: got %0d/%b/%b want 0/0/0", hz.stall_count, hz.mem_timeout, dbg_state); end
        set_idle();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL mwr_release: got %b want %b", ctl, C_NORMAL); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_rt_filter();
        test_branch();
        test_simultaneous();
        test_mem_wait();
        test_abort();
        test_timeout();
        test_mid_wait_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 8'd255, range 1..255: maximum MEM_WAIT cycles before timeout.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ID_registers_Rs, ID_registers_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 ID_uses_Rt  in  1  ID instruction reads Rt as a source.
REQ-006 ID_branch_taken  in  1  ID resolved a taken branch or jump.
REQ-007 EX_register_Rt  in  5; EX_MemRead  in  1  destination and load flag of the instruction in EX.
REQ-008 MEM_mem_req  in  1; MEM_mem_ready  in  1  data-memory access request and completion in MEM.
REQ-009 PC_write  out  1  PC update enable.
REQ-010 IF_ID_write  out  1  IF/ID register load enable.
REQ-011 IF_ID_flush  out  1  zero the IF/ID instruction.
REQ-012 ID_EX_flush  out  1  drives the ID/EX register flush input and inserts a bubble.
REQ-013 pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
REQ-014 mem_timeout  out  1  sticky memory-timeout error flag.
REQ-015 stall_count  out  16  stall-cycle performance counter.

Function
REQ-016 FSM states: RUN and MEM_WAIT, with an 8-bit wait_cnt.
REQ-017 load_use = EX_MemRead & (EX_register_Rt != 0) & ((EX_register_Rt == ID_registers_Rs) | (ID_uses_Rt & EX_register_Rt == ID_registers_Rt)).
REQ-018 hold = MEM_mem_req & ~MEM_mem_ready & ~(state==MEM_WAIT & wait_cnt==WAIT_LIMIT).
REQ-019 Priority, evaluated combinationally each cycle: hold > load_use > ID_branch_taken > normal.
REQ-020 hold: pipe_hold=1, PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=0.
REQ-021 load_use without hold: PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0, pipe_hold=0; exactly one bubble per hazard.
REQ-022 ID_branch_taken without hold or load_use: IF_ID_flush=1, PC_write=1, IF_ID_write=1, ID_EX_flush=0, pipe_hold=0.
REQ-023 Normal: PC_write=1, IF_ID_write=1, all flushes and pipe_hold 0.
REQ-024 RUN -> MEM_WAIT when hold=1; wait_cnt <= 1.
REQ-025 MEM_WAIT: MEM_mem_ready=1 -> RUN, wait_cnt <= 0; hold releases in the same cycle ready is seen.
REQ-026 MEM_WAIT: MEM_mem_req=0 (abort) -> RUN, wait_cnt <= 0.
REQ-027 MEM_WAIT: no ready and wait_cnt < WAIT_LIMIT -> wait_cnt increments.
REQ-028 MEM_WAIT: wait_cnt == WAIT_LIMIT and no ready -> mem_timeout <= 1, RUN, wait_cnt <= 0; hold deasserted in that cycle.
REQ-029 mem_timeout stays set until reset.
REQ-030 Simultaneous branch and load_use: the branch is not flushed; it is re-evaluated next cycle from the held ID instruction.

Reset
REQ-031 rst_n low: state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, taking effect immediately.
REQ-032 While rst_n is low, outputs forced to PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, pipe_hold=0.
REQ-033 Reset asserted during MEM_WAIT abandons the wait with no timeout recorded.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN.
REQ-035 With HAZARD_PERF_CNT_EN defined: stall_count increments on each cycle with PC_write=0 while rst_n is high, saturating at 16'hFFFF.
REQ-036 Without HAZARD_PERF_CNT_EN: the port remains present, tied to 16'h0000, and no counter logic is built.

Verification
REQ-037 Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; then EX_MemRead=0 -> normal outputs.
REQ-038 Rt filter: EX_Rt=0 with ID_Rs=0, and EX_Rt=7 with ID_Rt=7 and ID_uses_Rt=0 -> no stall in either case.
REQ-039 Memory wait: mem_req=1 with ready asserted on the 4th cycle -> pipe_hold=1 for 3 cycles, 0 in the ready cycle; state returns to RUN.
REQ-040 Timeout: WAIT_LIMIT=4, mem_req=1, ready never -> hold for 4 cycles, then mem_timeout=1 sticky and hold=0.
REQ-041 Simultaneous: branch_taken=1 with load_use=1 -> ID_EX_flush=1 and IF_ID_flush=0; the next cycle gives IF_ID_flush=1.
REQ-042 Mid-wait reset with HAZARD_PERF_CNT_EN: rst_n low in cycle 2 of MEM_WAIT -> state=RUN, stall_count=0, flushes asserted, mem_timeout=0.
